// File: rtl/prim_pad_bank.sv
// Pad bank: per-pad inv/open-drain output drive, 2-flop input sync,
// optional glitch filter (PRIM_PAD_BANK_FILTER_EN) and edge pulses.
module prim_pad_bank #(
  parameter int NumPads    = 4,
  parameter int AttrDw     = 10,
  parameter int FiltCycles = 4,
  localparam int IdxW = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  inout  wire  [NumPads-1:0]        pad_io,
  input  logic [NumPads-1:0]        out_i,
  input  logic [NumPads-1:0]        oe_i,
  input  logic [NumPads-1:0]        ie_i,
  output logic [NumPads-1:0]        in_o,
  output logic [NumPads-1:0]        rise_o,
  output logic [NumPads-1:0]        fall_o,
  input  logic                      attr_we_i,
  input  logic [IdxW-1:0]           attr_idx_i,
  input  logic [AttrDw-1:0]         attr_wdata_i,
  output logic [NumPads*AttrDw-1:0] attr_o
);

`ifdef PRIM_PAD_BANK_FILTER_EN
  localparam logic [AttrDw-1:0] AttrMask = AttrDw'(7);
`else
  localparam logic [AttrDw-1:0] AttrMask = AttrDw'(3);
`endif

  logic [NumPads-1:0][AttrDw-1:0] attr_q, attr_d;
  logic [NumPads-1:0] inv, od, out, drv;
  logic [NumPads-1:0] raw;
  logic [NumPads-1:0] s1_q, s2_q;
  logic [NumPads-1:0] in_q, in_d;
  logic [NumPads-1:0] dly_q;
  logic [NumPads-1:0] rise_q, fall_q;

  always_comb begin
    attr_d = attr_q;
    for (int i = 0; i < NumPads; i++) begin
      if (attr_we_i && attr_idx_i == IdxW'(i)) begin
        attr_d[i] = attr_wdata_i & AttrMask;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumPads; i++) begin
      inv[i] = attr_q[i][0];
      od[i]  = attr_q[i][1];
    end
  end

  assign out = out_i ^ inv;
  // Open-drain pads release the line instead of driving a one.
  assign drv = oe_i & ~(od & out);

  for (genvar g = 0; g < NumPads; g++) begin : g_pad
    assign pad_io[g] = drv[g] ? out[g] : 1'bz;
  end

  assign raw = (pad_io ^ inv) & ie_i;

`ifdef PRIM_PAD_BANK_FILTER_EN
  localparam int CntW = $clog2(FiltCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(FiltCycles - 1);

  logic [NumPads-1:0][CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    in_d  = in_q;
    for (int i = 0; i < NumPads; i++) begin
      if (!attr_q[i][2]) begin
        in_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else if (s2_q[i] != in_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          in_d[i]  = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
      // Toggling filt_en restarts the stability count.
      if (attr_d[i][2] != attr_q[i][2]) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign in_d = s2_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      attr_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      in_q   <= '0;
      dly_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      attr_q <= attr_d;
      s1_q   <= raw;
      s2_q   <= s1_q;
      in_q   <= in_d;
      dly_q  <= in_q;
      rise_q <= in_q & ~dly_q;
      fall_q <= ~in_q & dly_q;
    end
  end

  assign in_o   = in_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign attr_o = attr_q;

endmodule

// File: tb/tb_prim_pad_bank.sv
// Directed bench for prim_pad_bank (3 pads so an out-of-range
// attribute index exists); filter checks follow PRIM_PAD_BANK_FILTER_EN.
module tb_prim_pad_bank;
  localparam int NP = 3;
  localparam int AW = 10;
`ifdef PRIM_PAD_BANK_FILTER_EN
  localparam logic [9:0] MASK = 10'h007;
`else
  localparam logic [9:0] MASK = 10'h003;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  wire  [NP-1:0] pad_io;
  logic [NP-1:0] out_i = '0, oe_i = '0, ie_i = '0;
  logic [NP-1:0] in_o, rise_o, fall_o;
  logic          we = 1'b0;
  logic [1:0]    idx = '0;
  logic [AW-1:0] wdata = '0;
  logic [NP*AW-1:0] attr_o;
  logic [NP-1:0] tb_en = '0, tb_v = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NP; k++) begin : g_drv
    assign pad_io[k] = tb_en[k] ? tb_v[k] : 1'bz;
  end

  prim_pad_bank #(.NumPads(NP), .AttrDw(AW), .FiltCycles(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pad_io(pad_io),
    .out_i(out_i), .oe_i(oe_i), .ie_i(ie_i),
    .in_o(in_o), .rise_o(rise_o), .fall_o(fall_o),
    .attr_we_i(we), .attr_idx_i(idx), .attr_wdata_i(wdata),
    .attr_o(attr_o)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] i, input logic [AW-1:0] d);
    we = 1'b1; idx = i; wdata = d;
    tick(1);
    we = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_in", 32'(in_o), 0);
    check("rst_rise", 32'(rise_o), 0);
    check("rst_fall", 32'(fall_o), 0);
    check("rst_attr", 32'(attr_o), 0);
    rst_n = 1'b1;
    tick(1);

    out_i[0] = 1'b1; oe_i[0] = 1'b1; #1;
    check("drv1_val", 32'(pad_io[0]), 1);
    check("drv1_notz", 32'(pad_io[0] === 1'bz), 0);
    oe_i[0] = 1'b0; #1;
    check("oe0_z", 32'(pad_io[0] === 1'bz), 1);

    wr(2'd0, 10'h3FF);
    check("attr_warl", 32'(attr_o), 32'(MASK));
    wr(2'd3, 10'h3FF);
    check("attr_oob", 32'(attr_o), 32'(MASK));
    wr(2'd1, 10'h3FF);
    check("attr_p1", 32'(attr_o), (32'(MASK) << 10) | 32'(MASK));
    wr(2'd1, 10'h000);

    wr(2'd0, 10'h002);
    oe_i[0] = 1'b1; out_i[0] = 1'b1; #1;
    check("od_hi_z", 32'(pad_io[0] === 1'bz), 1);
    out_i[0] = 1'b0; #1;
    check("od_lo_val", 32'(pad_io[0]), 0);
    check("od_lo_notz", 32'(pad_io[0] === 1'bz), 0);
    wr(2'd0, 10'h003);
    out_i[0] = 1'b0; #1;
    check("odinv_z", 32'(pad_io[0] === 1'bz), 1);
    out_i[0] = 1'b1; #1;
    check("odinv_val", 32'(pad_io[0]), 0);
    check("odinv_notz", 32'(pad_io[0] === 1'bz), 0);
    oe_i[0] = 1'b0;
    wr(2'd0, 10'h000);

    tb_en[1] = 1'b1; tb_v[1] = 1'b1; ie_i[1] = 1'b1;
    tick(2);
    check("in_e2", 32'(in_o[1]), 0);
    tick(1);
    check("in_e3", 32'(in_o[1]), 1);
    check("rise_e3", 32'(rise_o[1]), 0);
    tick(1);
    check("rise_e4", 32'(rise_o[1]), 1);
    tick(1);
    check("rise_e5", 32'(rise_o[1]), 0);
    ie_i[1] = 1'b0;
    tick(2);
    check("ie0_e2", 32'(in_o[1]), 1);
    tick(1);
    check("ie0_e3", 32'(in_o[1]), 0);
    check("fall_e3", 32'(fall_o[1]), 0);
    tick(1);
    check("fall_e4", 32'(fall_o[1]), 1);
    tick(1);
    check("fall_e5", 32'(fall_o[1]), 0);

    tb_v[1] = 1'b0; ie_i[1] = 1'b1;
    wr(2'd1, 10'h001);
    tick(2);
    check("inv_e3", 32'(in_o[1]), 0);
    tick(1);
    check("inv_e4", 32'(in_o[1]), 1);
    wr(2'd1, 10'h000);
    tick(2);
    check("uninv_e3", 32'(in_o[1]), 1);
    tick(1);
    check("uninv_e4", 32'(in_o[1]), 0);

    tb_en[2] = 1'b1; tb_v[2] = 1'b0; ie_i[2] = 1'b1;
`ifdef PRIM_PAD_BANK_FILTER_EN
    wr(2'd2, 10'h004);
    tick(4);
    tb_v[2] = 1'b1;
    tick(3);
    tb_v[2] = 1'b0;
    tick(10);
    check("glitch_in", 32'(in_o[2]), 0);
    tb_v[2] = 1'b1;
    tick(5);
    check("filt_e5", 32'(in_o[2]), 0);
    tick(1);
    check("filt_e6", 32'(in_o[2]), 1);
    tick(4);
    tb_v[2] = 1'b0;
    tick(10);
    check("filt_low", 32'(in_o[2]), 0);
    tb_v[2] = 1'b1;
    tick(4);
`else
    tick(4);
    tb_v[2] = 1'b1;
    tick(2);
`endif
    rst_n = 1'b0; #1;
    check("mrst_in", 32'(in_o), 0);
    check("mrst_rise", 32'(rise_o), 0);
    check("mrst_fall", 32'(fall_o), 0);
    check("mrst_attr", 32'(attr_o), 0);
    tick(1);
    rst_n = 1'b1;
`ifdef PRIM_PAD_BANK_FILTER_EN
    wr(2'd2, 10'h004);
    tick(4);
    check("post_e5", 32'(in_o[2]), 0);
    tick(1);
    check("post_e6", 32'(in_o[2]), 1);
`else
    tick(2);
    check("post_e2", 32'(in_o[2]), 0);
    tick(1);
    check("post_e3", 32'(in_o[2]), 1);
`endif
    check("post_norise", 32'(rise_o[2]), 0);
    tick(1);
    check("post_rise", 32'(rise_o[2]), 1);
    tick(1);
    check("post_rise_end", 32'(rise_o[2]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prim_pad_bank.md
PRIM_PAD_BANK -- requirements
Module: prim_pad_bank

Interface
REQ-001 SHALL have parameter NumPads, default 4, number of pad channels (1..32).
REQ-002 SHALL have parameter AttrDw, default 10, attribute width per pad (>=3).
REQ-003 SHALL have parameter FiltCycles, default 4, glitch-filter stability count (>=2).
REQ-004 SHALL have port clk_i, input, 1, sole clock, all flops on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port pad_io, inout, NumPads, pad nets.
REQ-007 SHALL have port out_i, input, NumPads, core output data.
REQ-008 SHALL have port oe_i, input, NumPads, core output enable.
REQ-009 SHALL have port ie_i, input, NumPads, input enable.
REQ-010 SHALL have port in_o, output, NumPads, synchronised/filtered input data.
REQ-011 SHALL have ports rise_o and fall_o, output, NumPads each, one-cycle edge pulses of in_o.
REQ-012 SHALL have ports attr_we_i (input, 1), attr_idx_i (input, $clog2(NumPads), min 1) and attr_wdata_i (input, AttrDw), the attribute write port.
REQ-013 SHALL have port attr_o, output, NumPads*AttrDw, current WARL attribute registers, pad i at [i*AttrDw +: AttrDw].

Function
REQ-014 SHALL define attribute bits as: bit0 inv, bit1 od (open-drain), bit2 filt_en; all other bits SHALL be WARL and read back 0.
REQ-015 SHALL write attr_wdata_i, WARL-masked, into register attr_idx_i on the clock edge where attr_we_i=1; writes with attr_idx_i>=NumPads SHALL be ignored.
REQ-016 SHALL compute per-pad output combinationally: out=out_i^inv; pad_io driven with out when oe_i=1 and not (od and out=1); otherwise pad_io SHALL be high-Z.
REQ-017 SHALL form raw input = (pad_io^inv)&ie_i and pass it through a 2-flop synchroniser (s1, s2).
REQ-018 With filt_en=0, in_o SHALL register s2 each edge (latency of 3 edges from a pad change).
REQ-019 With filt_en=1, a per-pad counter SHALL increment each edge while s2!=in_o and clear when s2==in_o; in_o SHALL take s2 on the edge where the counter equals FiltCycles-1 and s2!=in_o, the counter clearing on the same edge (latency of 2+FiltCycles edges).
REQ-020 A glitch on s2 shorter than FiltCycles cycles with filt_en=1 SHALL NOT change in_o.
REQ-021 The counter width SHALL be $clog2(FiltCycles); the counter SHALL never wrap.
REQ-022 A write changing filt_en SHALL clear that pad's counter on the same edge.
REQ-023 rise_o[i]/fall_o[i] SHALL pulse for exactly one cycle, in the cycle after in_o[i] goes 0->1 / 1->0.
REQ-024 A simultaneous attribute write and pad change SHALL apply the new inv to the raw input from the following cycle; no other interaction is required.

Reset
REQ-025 While rst_ni=0: in_o, rise_o, fall_o, s1, s2, counters and all attribute registers SHALL be 0; pad_io SHALL follow REQ-016 with inv=od=0.
REQ-026 Reset assertion mid-filter SHALL discard the count; after release, a high pad SHALL produce rise_o after the normal latency.

Configuration
REQ-027 Macro PRIM_PAD_BANK_FILTER_EN defined: glitch filter, counters and filt_en bit SHALL be present per REQ-019..022.
REQ-028 Macro PRIM_PAD_BANK_FILTER_EN undefined: no counters SHALL be instantiated, filt_en SHALL be WARL read-0, and in_o SHALL always behave per REQ-018.

Verification
REQ-029 Reset, attr=0, oe=1, out_i=1 on pad0 -> pad0 driven 1; oe=0 -> pad0 high-Z; attr_o=0.
REQ-030 Write idx0 attr=0x3FF -> attr_o[9:0]=0x007; write idx=NumPads -> attr_o unchanged.
REQ-031 od=1, oe=1, out_i=1 -> pad high-Z; out_i=0 -> pad driven 0; inv=1, out_i=0 -> pad high-Z.
REQ-032 filt_en=0, ie=1, pad 0->1 -> in_o=1 at edge 3, rise_o one cycle after; ie=0 -> in_o falls after 3 edges, fall_o pulses.
REQ-033 filt_en=1, FiltCycles=4: 3-cycle high glitch -> in_o stays 0; 10-cycle high -> in_o=1 at edge 6.
REQ-034 Filter counting at 2, rst_ni pulsed low -> all outputs 0 immediately; pad held high -> rise_o after 6 edges.
